seg_scan_decoder: RTL and testbench

Receive-side counterpart of the four-digit 7-segment scan driver. Samples the multiplexed `segments`/`enables` bus on `fast_clk` and decodes each segment pattern back to a digit. Reassembles complete MM:SS frames and flags malformed scans. Used as a loopback monitor in the stopwatch top level and as the checker for display bench tests.

---
 rtl/seg_scan_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Loopback decoder for the four-digit 7-segment scan bus: samples the
// multiplexed segments/enables, rebuilds MM:SS frames and flags bad scans.
module seg_scan_decoder #(
  parameter int unsigned SETTLE  = 1,
  parameter int unsigned GAP_MAX = 8
) (
  input  logic       fast_clk,
  input  logic       rst_n,
  input  logic [7:0] segments,
  input  logic [3:0] enables,
  output logic [3:0] minutes_tens,
  output logic [3:0] minutes_ones,
  output logic [3:0] seconds_tens,
  output logic [3:0] seconds_ones,
  output logic [3:0] dp,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       order_err,
  output logic [7:0] frame_count
);

  localparam int unsigned STAB_W  = 5;
  localparam int unsigned GAP_W   = 8;
  localparam int unsigned DIGIT_W = 4;

  localparam logic [STAB_W-1:0]  STAB_SAT = '1;
  localparam logic [GAP_W-1:0]   GAP_SAT  = '1;
  localparam logic [DIGIT_W-1:0] BLANK    = 4'hA;
  localparam logic [DIGIT_W-1:0] BAD      = 4'hF;

  typedef enum logic [1:0] {HUNT, P2, P1, P0} state_t;

  state_t               state_q, state_d;
  logic [3:0]           en_q;
  logic [STAB_W-1:0]    stab_q, stab_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [DIGIT_W-1:0]   sh3_q, sh3_d, sh2_q, sh2_d, sh1_q, sh1_d;
  logic [3:1]           sdp_q, sdp_d;

  logic [DIGIT_W-1:0]   mt_d, mo_d, st_d, so_d;
  logic [3:0]           dp_d;
  logic                 fv_d, se_d, oe_d;
  logic [7:0]           cnt_d;

  logic [DIGIT_W-1:0]   digit_c;
  logic                 code_ok_c;
  logic                 dp_bit_c;
  logic [1:0]           pos_c;
  logic [1:0]           exp_pos_c;
  logic                 single_c, gap_c, illegal_c;
  logic                 accept_c, gap_to_c;

  // Segment code table; bit 7 (dp) is decoded separately.
  always_comb begin
    digit_c   = BAD;
    code_ok_c = 1'b1;
    case (segments[6:0])
      7'h40:   digit_c = 4'h0;
      7'h79:   digit_c = 4'h1;
      7'h24:   digit_c = 4'h2;
      7'h30:   digit_c = 4'h3;
      7'h19:   digit_c = 4'h4;
      7'h12:   digit_c = 4'h5;
      7'h02:   digit_c = 4'h6;
      7'h78:   digit_c = 4'h7;
      7'h00:   digit_c = 4'h8;
      7'h10:   digit_c = 4'h9;
      7'h7F:   digit_c = BLANK;
      default: code_ok_c = 1'b0;
    endcase
  end

  assign dp_bit_c = ~segments[7];

  // Enable classification: single position, gap, or illegal.
  always_comb begin
    pos_c    = 2'd0;
    single_c = 1'b1;
    case (enables)
      4'b0111: pos_c = 2'd3;
      4'b1011: pos_c = 2'd2;
      4'b1101: pos_c = 2'd1;
      4'b1110: pos_c = 2'd0;
      default: single_c = 1'b0;
    endcase
  end

  assign gap_c     = (enables == 4'b1111);
  assign illegal_c = !single_c && !gap_c;

  // Counters saturate above any legal threshold so each hit happens once.
  always_comb begin
    stab_d = '0;
    gap_d  = '0;
    if (enables != en_q) begin
      stab_d = STAB_W'(1);
    end else if (stab_q == STAB_SAT) begin
      stab_d = STAB_SAT;
    end else begin
      stab_d = stab_q + STAB_W'(1);
    end
    if (gap_c) begin
      gap_d = (gap_q == GAP_SAT) ? GAP_SAT : gap_q + GAP_W'(1);
    end
  end

  assign accept_c = single_c && (stab_d == STAB_W'(SETTLE));
  assign gap_to_c = gap_c && (gap_d == GAP_W'(GAP_MAX));

  always_comb begin
    case (state_q)
      P2:      exp_pos_c = 2'd2;
      P1:      exp_pos_c = 2'd1;
      default: exp_pos_c = 2'd0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    sh3_d   = sh3_q;
    sh2_d   = sh2_q;
    sh1_d   = sh1_q;
    sdp_d   = sdp_q;
    mt_d    = minutes_tens;
    mo_d    = minutes_ones;
    st_d    = seconds_tens;
    so_d    = seconds_ones;
    dp_d    = dp;
    cnt_d   = frame_count;
    fv_d    = 1'b0;
    oe_d    = 1'b0;
    se_d    = accept_c && !code_ok_c;

    if (state_q == HUNT) begin
      if (accept_c && pos_c == 2'd3) begin
        sh3_d    = digit_c;
        sdp_d[3] = dp_bit_c;
        state_d  = P2;
      end
    end else if (illegal_c || gap_to_c) begin
      oe_d    = 1'b1;
      state_d = HUNT;
    end else if (accept_c && pos_c == exp_pos_c) begin
      case (state_q)
        P2: begin
          sh2_d    = digit_c;
          sdp_d[2] = dp_bit_c;
          state_d  = P1;
        end
        P1: begin
          sh1_d    = digit_c;
          sdp_d[1] = dp_bit_c;
          state_d  = P0;
        end
        default: begin
          mt_d    = sh3_q;
          mo_d    = sh2_q;
          st_d    = sh1_q;
          so_d    = digit_c;
          dp_d    = {sdp_q, dp_bit_c};
          fv_d    = 1'b1;
          cnt_d   = frame_count + 8'd1;
          state_d = HUNT;
        end
      endcase
    end else if (accept_c) begin
      // A fresh position 3 restarts capture rather than waiting for the next scan.
      oe_d = 1'b1;
      if (pos_c == 2'd3) begin
        sh3_d    = digit_c;
        sdp_d[3] = dp_bit_c;
        state_d  = P2;
      end else begin
        state_d = HUNT;
      end
    end
  end

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      en_q         <= 4'b1111;
      stab_q       <= '0;
      gap_q        <= '0;
      sh3_q        <= BLANK;
      sh2_q        <= BLANK;
      sh1_q        <= BLANK;
      sdp_q        <= '0;
      minutes_tens <= BLANK;
      minutes_ones <= BLANK;
      seconds_tens <= BLANK;
      seconds_ones <= BLANK;
      dp           <= '0;
      frame_valid  <= 1'b0;
      seg_err      <= 1'b0;
      order_err    <= 1'b0;
      frame_count  <= '0;
    end else begin
      state_q      <= state_d;
      en_q         <= enables;
      stab_q       <= stab_d;
      gap_q        <= gap_d;
      sh3_q        <= sh3_d;
      sh2_q        <= sh2_d;
      sh1_q        <= sh1_d;
      sdp_q        <= sdp_d;
      minutes_tens <= mt_d;
      minutes_ones <= mo_d;
      seconds_tens <= st_d;
      seconds_ones <= so_d;
      dp           <= dp_d;
      frame_valid  <= fv_d;
      seg_err      <= se_d;
      order_err    <= oe_d;
      frame_count  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: drivers queue expected frames and
// error pulses, a negedge monitor pops and compares them against the DUTs.
module tb_seg_scan_decoder;

  logic       fast_clk;
  logic       rst_n;
  logic [7:0] seg_a, seg_b;
  logic [3:0] en_a, en_b;
  logic [3:0] mt_a, mo_a, st_a, so_a, dp_a;
  logic [3:0] mt_b, mo_b, st_b, so_b, dp_b;
  logic       fv_a, se_a, oe_a, fv_b, se_b, oe_b;
  logic [7:0] fc_a, fc_b;

  typedef struct {
    int         cyc;
    logic [3:0] mt, mo, st, so, dp;
    logic [7:0] cnt;
  } frame_t;

  frame_t fq_a[$];
  frame_t fq_b[$];
  int     sq_a[$];
  int     oq_a[$];

  int         cyc   = 0;
  int         total = 0;
  int         bad   = 0;
  logic       done  = 1'b0;
  logic [7:0] cnt_a = 8'd0;
  logic [7:0] cnt_b = 8'd0;
  frame_t     cur;
  frame_t     e;

  localparam logic [30:0] RST_VEC = {4'hA, 4'hA, 4'hA, 4'hA, 4'h0, 3'b000, 8'h00};

  seg_scan_decoder #(.SETTLE(1), .GAP_MAX(8)) dut_a (
    .fast_clk(fast_clk), .rst_n(rst_n), .segments(seg_a), .enables(en_a),
    .minutes_tens(mt_a), .minutes_ones(mo_a), .seconds_tens(st_a), .seconds_ones(so_a),
    .dp(dp_a), .frame_valid(fv_a), .seg_err(se_a), .order_err(oe_a), .frame_count(fc_a)
  );

  seg_scan_decoder #(.SETTLE(3), .GAP_MAX(8)) dut_b (
    .fast_clk(fast_clk), .rst_n(rst_n), .segments(seg_b), .enables(en_b),
    .minutes_tens(mt_b), .minutes_ones(mo_b), .seconds_tens(st_b), .seconds_ones(so_b),
    .dp(dp_b), .frame_valid(fv_b), .seg_err(se_b), .order_err(oe_b), .frame_count(fc_b)
  );

  initial fast_clk = 1'b0;
  always #5 fast_clk = ~fast_clk;

  always @(posedge fast_clk) cyc <= cyc + 1;

  // Monitor: all comparisons and the summary live here.
  always @(negedge fast_clk) begin
    if (done) begin
      total++;
      if (fq_a.size() + fq_b.size() + sq_a.size() + oq_a.size() != 0) begin
        bad++;
        $display("FAIL leftover expectations: frames_a=%0d frames_b=%0d seg_a=%0d order_a=%0d, required all 0",
                 fq_a.size(), fq_b.size(), sq_a.size(), oq_a.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else if (!rst_n) begin
      cur = '{0, 4'hA, 4'hA, 4'hA, 4'hA, 4'h0, 8'h00};
      total++;
      if ({mt_a, mo_a, st_a, so_a, dp_a, fv_a, se_a, oe_a, fc_a} != RST_VEC) begin
        bad++;
        $display("FAIL reset_a cyc=%0d got=%h required=%h", cyc,
                 {mt_a, mo_a, st_a, so_a, dp_a, fv_a, se_a, oe_a, fc_a}, RST_VEC);
      end
      total++;
      if ({mt_b, mo_b, st_b, so_b, dp_b, fv_b, se_b, oe_b, fc_b} != RST_VEC) begin
        bad++;
        $display("FAIL reset_b cyc=%0d got=%h required=%h", cyc,
                 {mt_b, mo_b, st_b, so_b, dp_b, fv_b, se_b, oe_b, fc_b}, RST_VEC);
      end
    end else begin
      if (fv_a) begin
        total++;
        if (fq_a.size() == 0) begin
          bad++;
          $display("FAIL frame_a unexpected at cyc=%0d got=%h", cyc, {mt_a, mo_a, st_a, so_a, dp_a, fc_a});
        end else begin
          e = fq_a.pop_front();
          cur = e;
          if (e.cyc != cyc || {mt_a, mo_a, st_a, so_a, dp_a, fc_a} != {e.mt, e.mo, e.st, e.so, e.dp, e.cnt}) begin
            bad++;
            $display("FAIL frame_a cyc=%0d got=%h required cyc=%0d val=%h", cyc,
                     {mt_a, mo_a, st_a, so_a, dp_a, fc_a}, e.cyc, {e.mt, e.mo, e.st, e.so, e.dp, e.cnt});
          end
        end
      end
      total++;
      if ({mt_a, mo_a, st_a, so_a, dp_a, fc_a} != {cur.mt, cur.mo, cur.st, cur.so, cur.dp, cur.cnt}) begin
        bad++;
        $display("FAIL hold_a cyc=%0d got=%h required=%h", cyc,
                 {mt_a, mo_a, st_a, so_a, dp_a, fc_a}, {cur.mt, cur.mo, cur.st, cur.so, cur.dp, cur.cnt});
      end
      if (se_a) begin
        total++;
        if (sq_a.size() != 0 && sq_a[0] == cyc) begin
          void'(sq_a.pop_front());
        end else begin
          bad++;
          $display("FAIL seg_err_a pulse at cyc=%0d, required at %0d", cyc, (sq_a.size() != 0) ? sq_a[0] : -1);
        end
      end
      if (oe_a) begin
        total++;
        if (oq_a.size() != 0 && oq_a[0] == cyc) begin
          void'(oq_a.pop_front());
        end else begin
          bad++;
          $display("FAIL order_err_a pulse at cyc=%0d, required at %0d", cyc, (oq_a.size() != 0) ? oq_a[0] : -1);
        end
      end
      if (fv_b) begin
        total++;
        if (fq_b.size() == 0) begin
          bad++;
          $display("FAIL frame_b unexpected at cyc=%0d got=%h", cyc, {mt_b, mo_b, st_b, so_b, dp_b, fc_b});
        end else begin
          e = fq_b.pop_front();
          if (e.cyc != cyc || {mt_b, mo_b, st_b, so_b, dp_b, fc_b} != {e.mt, e.mo, e.st, e.so, e.dp, e.cnt}) begin
            bad++;
            $display("FAIL frame_b cyc=%0d got=%h required cyc=%0d val=%h", cyc,
                     {mt_b, mo_b, st_b, so_b, dp_b, fc_b}, e.cyc, {e.mt, e.mo, e.st, e.so, e.dp, e.cnt});
          end
        end
      end
      total++;
      if (se_b || oe_b) begin
        bad++;
        $display("FAIL errs_b cyc=%0d got seg=%b order=%b required 0 0", cyc, se_b, oe_b);
      end
    end
  end

  // Drive one sample; c is the cycle at which its effect is visible.
  task automatic stp_a(input logic [3:0] en, input logic [7:0] sg, output int c);
    c = cyc + 1;
    en_a = en;
    seg_a = sg;
    @(posedge fast_clk);
    #1;
  endtask

  task automatic stp_b(input logic [3:0] en, input logic [7:0] sg, output int c);
    c = cyc + 1;
    en_b = en;
    seg_b = sg;
    @(posedge fast_clk);
    #1;
  endtask

  task automatic push_a(input int c, input logic [3:0] mt, mo, st, so, dpx);
    cnt_a = cnt_a + 8'd1;
    fq_a.push_back('{c, mt, mo, st, so, dpx, cnt_a});
  endtask

  task automatic scan_a(input logic [7:0] s3, s2, s1, s0,
                        input logic [3:0] mt, mo, st, so, dpx, bad_m);
    int c;
    stp_a(4'b0111, s3, c); if (bad_m[3]) sq_a.push_back(c);
    stp_a(4'b1011, s2, c); if (bad_m[2]) sq_a.push_back(c);
    stp_a(4'b1101, s1, c); if (bad_m[1]) sq_a.push_back(c);
    stp_a(4'b1110, s0, c); if (bad_m[0]) sq_a.push_back(c);
    push_a(c, mt, mo, st, so, dpx);
  endtask

  logic [3:0] ens[4];
  logic [7:0] sgs[4];

  initial begin
    int c;
    ens = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    sgs = '{8'hC0, 8'hA4, 8'hB0, 8'h92};
    rst_n = 1'b0;
    en_a = 4'hF; seg_a = 8'hFF;
    en_b = 4'hF; seg_b = 8'hFF;
    repeat (3) @(posedge fast_clk);
    #1;
    rst_n = 1'b1;
    stp_a(4'hF, 8'hFF, c);

    // Normal scan, then a pattern with decimal points lit on mt and st
    repeat (3) scan_a(8'hC0, 8'hA4, 8'hB0, 8'h92, 4'h0, 4'h2, 4'h3, 4'h5, 4'b0000, 4'b0000);
    scan_a(8'h79, 8'hA4, 8'h19, 8'h90, 4'h1, 4'h2, 4'h4, 4'h9, 4'b1010, 4'b0000);

    // Order violation 3,2,0 then a clean scan
    stp_a(4'b0111, 8'hC0, c);
    stp_a(4'b1011, 8'hA4, c);
    stp_a(4'b1110, 8'h92, c); oq_a.push_back(c);
    stp_a(4'hF, 8'hFF, c);
    scan_a(8'hF8, 8'h82, 8'h99, 8'h80, 4'h7, 4'h6, 4'h4, 4'h8, 4'b0000, 4'b0000);

    // Blank on position 2, undecodable 0x55 on position 1
    scan_a(8'hC0, 8'hFF, 8'h55, 8'h92, 4'h0, 4'hA, 4'hF, 4'h5, 4'b0010, 4'b0010);

    // Seven gap cycles before position 0 are tolerated
    stp_a(4'b0111, 8'hC0, c);
    stp_a(4'b1011, 8'hA4, c);
    stp_a(4'b1101, 8'hB0, c);
    repeat (7) stp_a(4'hF, 8'hFF, c);
    stp_a(4'b1110, 8'h92, c);
    push_a(c, 4'h0, 4'h2, 4'h3, 4'h5, 4'b0000);

    // Eight gap cycles time out; the late position 0 is ignored in HUNT
    stp_a(4'b0111, 8'hC0, c);
    stp_a(4'b1011, 8'hA4, c);
    stp_a(4'b1101, 8'hB0, c);
    repeat (8) stp_a(4'hF, 8'hFF, c);
    oq_a.push_back(c);
    stp_a(4'b1110, 8'h92, c);

    // Illegal multi-low enable mid-frame
    stp_a(4'b0111, 8'hC0, c);
    stp_a(4'b1011, 8'hA4, c);
    stp_a(4'b0011, 8'hA4, c); oq_a.push_back(c);
    stp_a(4'b1101, 8'hB0, c);
    stp_a(4'b1110, 8'h92, c);
    stp_a(4'hF, 8'hFF, c);

    // SETTLE=3: two-cycle holds are rejected, three-cycle holds complete
    for (int i = 0; i < 4; i++) repeat (2) stp_b(ens[i], sgs[i], c);
    for (int i = 0; i < 4; i++) repeat (3) stp_b(ens[i], sgs[i], c);
    cnt_b = cnt_b + 8'd1;
    fq_b.push_back('{c, 4'h0, 4'h2, 4'h3, 4'h5, 4'b0000, cnt_b});
    stp_b(4'hF, 8'hFF, c);

    // Asynchronous reset mid-frame discards the partial capture
    stp_a(4'b0111, 8'hC0, c);
    stp_a(4'b1011, 8'hA4, c);
    rst_n = 1'b0;
    en_a = 4'hF; seg_a = 8'hFF;
    @(posedge fast_clk);
    #1;
    @(posedge fast_clk);
    #1;
    rst_n = 1'b1;
    cnt_a = 8'd0;
    cnt_b = 8'd0;
    stp_a(4'b1101, 8'hB0, c);
    stp_a(4'b1110, 8'h92, c);

    // 256 frames after reset: frame_count wraps back to 0
    for (int i = 0; i < 256; i++)
      scan_a(8'hC0, 8'hA4, 8'hB0, 8'h92, 4'h0, 4'h2, 4'h3, 4'h5, 4'b0000, 4'b0000);
    repeat (3) stp_a(4'hF, 8'hFF, c);

    done = 1'b1;
    repeat (4) @(posedge fast_clk);
    $display("FAIL monitor did not finish");
    $fatal(1);
  end

endmodule
